microsequencer: RTL and testbench
=================================

MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 Parameter ADDR_W, default 9: control-store address width.
REQ-002 Parameter ALU_W, default 8: ALU field width.
REQ-003 Parameter C_W, default 9: C-bus field width.
REQ-004 Parameter MEM_W, default 3: MEM field width.
REQ-005 Parameter B_W, default 4: B-bus field width.
REQ-006 Parameter MBR_W, default 8: MBR width for JMPC dispatch.
REQ-007 Derived: UW = ADDR_W+3+ALU_W+C_W+MEM_W+B_W (default 36) control-store word width; MW = ALU_W+C_W+MEM_W+B_W (default 24).
REQ-008 Port: clk, input, 1, sole clock, rising edge.
REQ-009 Port: reset, input, 1, asynchronous active-low reset.
REQ-010 Port: start, input, 1, single-cycle pulse; begins execution from IDLE.
REQ-011 Port: stall, input, 1, memory wait; freezes sequencing while high.
REQ-012 Port: n, input, 1, datapath ALU negative flag for the current microinstruction.
REQ-013 Port: z, input, 1, datapath ALU zero flag for the current microinstruction.
REQ-014 Port: mbr, input, MBR_W, datapath MBR value for JMPC.
REQ-015 Port: cs_we, input, 1, control-store write enable.
REQ-016 Port: cs_waddr, input, ADDR_W, control-store write address.
REQ-017 Port: cs_wdata, input, UW, control-store write data.
REQ-018 Port: microinst, output, MW, {ALU,C,MEM,B} fields driven to the datapath.
REQ-019 Port: mpc, output, ADDR_W, address of the microinstruction currently in MIR.
REQ-020 Port: halted, output, 1, high in HALT.

Function
REQ-021 The block SHALL hold a 2^ADDR_W x UW control store, synchronous write, combinational read; MIR register UW bits.
REQ-022 Word layout SHALL be [UW-1 -: ADDR_W] NEXT, then JMPC, JAMN, JAMZ, then ALU, C, MEM, B (B in LSBs).
REQ-023 States SHALL be IDLE, RUN, STALL, HALT.
REQ-024 In IDLE, cs_we=1 SHALL write cs_wdata to cs[cs_waddr] at the clock edge; cs_we SHALL be ignored in all other states.
REQ-025 IDLE with start=1 and cs_we=0 SHALL load mir<=cs[0], mpc<=0, go to RUN; start with cs_we=1 SHALL be ignored.
REQ-026 Next address: hi = NEXT[ADDR_W-1] | (JAMN&n) | (JAMZ&z); lo = NEXT[ADDR_W-2:0], with lo[MBR_W-1:0] ORed with mbr when JMPC=1; addr = {hi, lo}.
REQ-027 In RUN with stall=0 and no halt condition, each edge SHALL set mpc<=addr and mir<=cs[addr]; throughput one microinstruction per cycle.
REQ-028 n, z, mbr SHALL be used only in RUN with stall=0, combinationally in the same cycle microinst is driven.
REQ-029 microinst SHALL equal mir[MW-1:0] in RUN, and all zeros (NOP) in IDLE, STALL and HALT.
REQ-030 RUN with stall=1 SHALL go to STALL at the edge, holding mir and mpc; STALL with stall=0 SHALL return to RUN at the edge; mir and mpc remain unchanged throughout.
REQ-031 Halt condition: JAM=000 and NEXT==mpc in RUN with stall=0; the edge SHALL go to HALT, mir and mpc unchanged.
REQ-032 HALT SHALL persist until reset; start, stall, cs_we ignored; halted=1 only in HALT.
REQ-033 stall=1 with halt condition in the same cycle: stall SHALL take priority (go to STALL).
REQ-034 Address arithmetic SHALL wrap within ADDR_W bits; no overflow detection.

Reset
REQ-035 reset=0 SHALL immediately force state IDLE, mir=0, mpc=0, halted=0, microinst=0, regardless of clk.
REQ-036 Control-store contents SHALL be unaffected by reset; reset asserted mid-RUN or mid-STALL SHALL abort with no further writes.
REQ-037 Release of reset SHALL take effect at the next rising edge; no start is honoured in the release cycle's preceding low phase.

Verification
REQ-038 Load cs[0]={NEXT=1,JAM=0,ALU=8'h3C}, cs[1]={NEXT=1,JAM=0}; start -> microinst ALU=8'h3C at mpc=0, next cycle mpc=1, following cycle halted=1, microinst=0.
REQ-039 cs[2]={NEXT=9'h005,JAMZ=1}; z=1 -> mpc=9'h105; z=0 -> mpc=9'h005; JAMN with n=1 likewise -> 9'h105.
REQ-040 cs[3]={NEXT=9'h100,JMPC=1}, mbr=8'h60 -> mpc=9'h160, mir=cs[9'h160].
REQ-041 stall=1 for 3 cycles mid-RUN -> microinst=0 and mpc constant for 3 cycles, then sequencing resumes with the held MIR.
REQ-042 cs_we with cs_waddr=4 during RUN -> cs[4] unchanged; start with cs_we=1 in IDLE -> state stays IDLE.
REQ-043 reset=0 asynchronously mid-RUN -> outputs zero before the next edge; after release plus start, execution restarts at mpc=0 with the preserved control store.

Source files
------------

// File: rtl/microsequencer.sv
// Microprogrammed sequencer: writable control store, MIR, and a four-state
// IDLE/RUN/STALL/HALT controller computing the next address from the NEXT field,
// the JAM bits, the ALU flags and the MBR.
module microsequencer #(
  parameter int ADDR_W = 9,
  parameter int ALU_W  = 8,
  parameter int C_W    = 9,
  parameter int MEM_W  = 3,
  parameter int B_W    = 4,
  parameter int MBR_W  = 8,
  localparam int UW    = ADDR_W + 3 + ALU_W + C_W + MEM_W + B_W,
  localparam int MW    = ALU_W + C_W + MEM_W + B_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              n,
  input  logic              z,
  input  logic [MBR_W-1:0]  mbr,
  input  logic              cs_we,
  input  logic [ADDR_W-1:0] cs_waddr,
  input  logic [UW-1:0]     cs_wdata,
  output logic [MW-1:0]     microinst,
  output logic [ADDR_W-1:0] mpc,
  output logic              halted
);

  typedef enum logic [1:0] {IDLE, RUN, STALL, HALT} state_e;

  state_e              state_q, state_d;
  logic [UW-1:0]       mir_q, mir_d;
  logic [ADDR_W-1:0]   mpc_q, mpc_d;

  logic [UW-1:0]       cs_q [0:(1<<ADDR_W)-1];

  logic [ADDR_W-1:0]   nxt;
  logic                jmpc, jamn, jamz;
  logic [ADDR_W-2:0]   mbr_ext;
  logic [ADDR_W-2:0]   addr_lo;
  logic                addr_hi;
  logic [ADDR_W-1:0]   addr;
  logic                halt_cond;

  assign nxt  = mir_q[UW-1 -: ADDR_W];
  assign jmpc = mir_q[MW+2];
  assign jamn = mir_q[MW+1];
  assign jamz = mir_q[MW];

  // Next microinstruction address; the OR-only composition wraps naturally.
  always_comb begin
    mbr_ext              = '0;
    mbr_ext[MBR_W-1:0]   = mbr;
    addr_lo              = nxt[ADDR_W-2:0] | (jmpc ? mbr_ext : '0);
    addr_hi              = nxt[ADDR_W-1] | (jamn & n) | (jamz & z);
    addr                 = {addr_hi, addr_lo};
    halt_cond            = ({jmpc, jamn, jamz} == 3'b000) && (nxt == mpc_q);
  end

  // Control store write port, open only while idle; contents survive reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && cs_we) begin
      cs_q[cs_waddr] <= cs_wdata;
    end
  end

  // State, MIR and MPC registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mir_q   <= '0;
      mpc_q   <= '0;
    end else begin
      state_q <= state_d;
      mir_q   <= mir_d;
      mpc_q   <= mpc_d;
    end
  end

  // Next-state and MIR/MPC update; stall is checked before the halt condition.
  always_comb begin
    state_d = state_q;
    mir_d   = mir_q;
    mpc_d   = mpc_q;
    case (state_q)
      IDLE: begin
        if (start && !cs_we) begin
          state_d = RUN;
          mir_d   = cs_q[0];
          mpc_d   = '0;
        end
      end
      RUN: begin
        if (stall) begin
          state_d = STALL;
        end else if (halt_cond) begin
          state_d = HALT;
        end else begin
          mpc_d = addr;
          mir_d = cs_q[addr];
        end
      end
      STALL: begin
        if (!stall) begin
          state_d = RUN;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath outputs: MIR fields only while running, NOP otherwise.
  always_comb begin
    microinst = '0;
    if (state_q == RUN) begin
      microinst = mir_q[MW-1:0];
    end
    halted = (state_q == HALT);
    mpc    = mpc_q;
  end

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for microsequencer: table of next-address vectors plus
// hand-written sequences for halt, stall, write blocking and async reset.
module tb_microsequencer;

  localparam int AW = 9;
  localparam int UW = 36;
  localparam int MW = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic          n = 1'b0;
  logic          z = 1'b0;
  logic [7:0]    mbr = '0;
  logic          cs_we = 1'b0;
  logic [AW-1:0] cs_waddr = '0;
  logic [UW-1:0] cs_wdata = '0;
  logic [MW-1:0] microinst;
  logic [AW-1:0] mpc;
  logic          halted;

  int total = 0;
  int bad   = 0;

  microsequencer #(.ADDR_W(9), .ALU_W(8), .C_W(9), .MEM_W(3), .B_W(4), .MBR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stall     (stall),
    .n         (n),
    .z         (z),
    .mbr       (mbr),
    .cs_we     (cs_we),
    .cs_waddr  (cs_waddr),
    .cs_wdata  (cs_wdata),
    .microinst (microinst),
    .mpc       (mpc),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] src;
    logic [8:0] nxt;
    logic       jmpc;
    logic       jamn;
    logic       jamz;
    logic       vn;
    logic       vz;
    logic [7:0] vmbr;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [35:0] mkw(input logic [8:0] nx, input logic jc, input logic jn,
                                      input logic jz, input logic [7:0] alu, input logic [8:0] c,
                                      input logic [2:0] mem, input logic [3:0] b);
    return {nx, jc, jn, jz, alu, c, mem, b};
  endfunction

  // Default store image: each word halts on itself and has distinctive fields.
  function automatic logic [35:0] fillw(input logic [8:0] t);
    return mkw(t, 1'b0, 1'b0, 1'b0, t[7:0] ^ 8'h5A, {1'b1, t[7:0]}, t[2:0], t[3:0]);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cs_write(input logic [8:0] a, input logic [35:0] d);
    cs_we    = 1'b1;
    cs_waddr = a;
    cs_wdata = d;
    step();
    cs_we    = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [35:0] w;
    logic [35:0] junk;
    junk = 36'hF_FFFF_FFFF;

    vecs[0] = '{9'd2, 9'h005, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 9'h105};
    vecs[1] = '{9'd2, 9'h005, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 9'h005};
    vecs[2] = '{9'd2, 9'h005, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 9'h105};
    vecs[3] = '{9'd2, 9'h005, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 9'h005};
    vecs[4] = '{9'd3, 9'h100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h60, 9'h160};
    vecs[5] = '{9'd3, 9'h005, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA2, 9'h0A7};
    vecs[6] = '{9'd2, 9'h1F0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 9'h1F0};
    vecs[7] = '{9'd3, 9'h0F0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h0F, 9'h1FF};
    vecs[8] = '{9'd2, 9'h040, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 9'h040};

    // Reset state, visible before any clock edge.
    #1;
    chk("reset_microinst", 64'(microinst), 64'h0);
    chk("reset_mpc", 64'(mpc), 64'h0);
    chk("reset_halted", 64'(halted), 64'h0);
    step();
    step();
    reset = 1'b1;

    for (int i = 0; i < 512; i++) begin
      cs_write(9'(i), fillw(9'(i)));
    end

    // start together with cs_we must not leave IDLE.
    start    = 1'b1;
    cs_we    = 1'b1;
    cs_waddr = 9'h1E0;
    cs_wdata = fillw(9'h1E0);
    step();
    start = 1'b0;
    cs_we = 1'b0;
    chk("start_we_ignored_mi", 64'(microinst), 64'h0);
    step();
    chk("start_we_idle_mi", 64'(microinst), 64'h0);
    chk("start_we_idle_halted", 64'(halted), 64'h0);

    // Two-word program that halts on its second word.
    cs_write(9'd0, mkw(9'd1, 1'b0, 1'b0, 1'b0, 8'h3C, 9'h0, 3'h0, 4'h0));
    cs_write(9'd1, mkw(9'd1, 1'b0, 1'b0, 1'b0, 8'h00, 9'h0, 3'h0, 4'h0));
    do_start();
    chk("basic_mpc0", 64'(mpc), 64'h0);
    chk("basic_alu3c", 64'(microinst), 64'h3C_0000);
    step();
    chk("basic_mpc1", 64'(mpc), 64'h1);
    chk("basic_not_halted", 64'(halted), 64'h0);
    step();
    chk("basic_halted", 64'(halted), 64'h1);
    chk("basic_halt_mi", 64'(microinst), 64'h0);
    chk("basic_halt_mpc", 64'(mpc), 64'h1);
    start    = 1'b1;
    stall    = 1'b1;
    cs_we    = 1'b1;
    cs_waddr = 9'd4;
    cs_wdata = junk;
    step();
    step();
    start = 1'b0;
    stall = 1'b0;
    cs_we = 1'b0;
    chk("halt_sticky", 64'(halted), 64'h1);
    chk("halt_sticky_mpc", 64'(mpc), 64'h1);
    do_reset();
    chk("halt_cleared_by_reset", 64'(halted), 64'h0);

    // Next-address vectors: cs[0] jumps to src, src word dispatches to exp.
    for (int i = 0; i < 9; i++) begin
      cs_write(9'd0, mkw(vecs[i].src, 1'b0, 1'b0, 1'b0, 8'h01, 9'h0, 3'h0, 4'h0));
      cs_write(vecs[i].src, mkw(vecs[i].nxt, vecs[i].jmpc, vecs[i].jamn, vecs[i].jamz,
                                8'h00, 9'h0, 3'h0, 4'h0));
      do_start();
      chk($sformatf("vec%0d_mpc0", i), 64'(mpc), 64'h0);
      step();
      chk($sformatf("vec%0d_mpc_src", i), 64'(mpc), 64'(vecs[i].src));
      n   = vecs[i].vn;
      z   = vecs[i].vz;
      mbr = vecs[i].vmbr;
      step();
      w = fillw(vecs[i].exp);
      chk($sformatf("vec%0d_mpc", i), 64'(mpc), 64'(vecs[i].exp));
      chk($sformatf("vec%0d_mir", i), 64'(microinst), 64'(w[23:0]));
      n   = 1'b0;
      z   = 1'b0;
      mbr = '0;
      step();
      chk($sformatf("vec%0d_halt", i), 64'(halted), 64'h1);
      do_reset();
    end

    // Stall for three cycles, with a blocked store write during RUN.
    cs_write(9'd0,    mkw(9'h010, 1'b0, 1'b0, 1'b0, 8'h11, 9'h0, 3'h0, 4'h0));
    cs_write(9'h010,  mkw(9'h011, 1'b0, 1'b0, 1'b0, 8'h22, 9'h0, 3'h0, 4'h0));
    cs_write(9'h011,  mkw(9'h011, 1'b0, 1'b0, 1'b0, 8'h33, 9'h0, 3'h0, 4'h0));
    do_start();
    chk("stall_pre_mi", 64'(microinst), 64'h11_0000);
    stall    = 1'b1;
    cs_we    = 1'b1;
    cs_waddr = 9'd4;
    cs_wdata = junk;
    for (int c = 0; c < 3; c++) begin
      step();
      cs_we = 1'b0;
      chk($sformatf("stall%0d_mi", c), 64'(microinst), 64'h0);
      chk($sformatf("stall%0d_mpc", c), 64'(mpc), 64'h0);
    end
    stall = 1'b0;
    step();
    chk("resume_mpc", 64'(mpc), 64'h0);
    chk("resume_held_mir", 64'(microinst), 64'h11_0000);
    step();
    chk("resume_next_mpc", 64'(mpc), 64'h10);
    chk("resume_next_mi", 64'(microinst), 64'h22_0000);
    step();
    chk("pre_halt_mpc", 64'(mpc), 64'h11);
    stall = 1'b1;
    step();
    chk("stall_over_halt_halted", 64'(halted), 64'h0);
    chk("stall_over_halt_mi", 64'(microinst), 64'h0);
    stall = 1'b0;
    step();
    chk("stall_over_halt_resume", 64'(microinst), 64'h33_0000);
    step();
    chk("stall_then_halt", 64'(halted), 64'h1);
    do_reset();

    // cs[4] must still hold its original word after the blocked writes.
    cs_write(9'd0, mkw(9'd4, 1'b0, 1'b0, 1'b0, 8'h01, 9'h0, 3'h0, 4'h0));
    do_start();
    step();
    w = fillw(9'd4);
    chk("cs4_mpc", 64'(mpc), 64'h4);
    chk("cs4_unchanged", 64'(microinst), 64'(w[23:0]));
    do_reset();

    // Asynchronous reset mid-RUN, then restart with the preserved store.
    cs_write(9'd0, mkw(9'h020, 1'b0, 1'b0, 1'b0, 8'h44, 9'h0, 3'h0, 4'h0));
    do_start();
    step();
    w = fillw(9'h020);
    chk("async_pre_mpc", 64'(mpc), 64'h20);
    chk("async_pre_mi", 64'(microinst), 64'(w[23:0]));
    #2;
    reset = 1'b0;
    #1;
    chk("async_mi_zero", 64'(microinst), 64'h0);
    chk("async_mpc_zero", 64'(mpc), 64'h0);
    chk("async_halted_zero", 64'(halted), 64'h0);
    step();
    reset = 1'b1;
    do_start();
    chk("restart_mpc", 64'(mpc), 64'h0);
    chk("restart_mi", 64'(microinst), 64'h44_0000);
    step();
    chk("restart_next_mpc", 64'(mpc), 64'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
